// File: rtl/fc_alu_sequencer.sv
// Load-bus sequencer for a fully-connected layer. It latches one input vector,
// then, for each neuron, fetches {bias, weights}, loads the ALU, fires one compute and streams the result.
module fc_alu_sequencer #(
  parameter int SIZE      = 16,
  parameter int PRECISION = 11,
  parameter int INPUT_SZ  = 4,
  parameter int N_OUT     = 10,
  parameter int AW        = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [INPUT_SZ*SIZE-1:0]     in_values,
  output logic                         mem_rd,
  output logic [AW-1:0]                mem_addr,
  input  logic [(INPUT_SZ+1)*SIZE-1:0] mem_rdata,
  output logic [(INPUT_SZ+1)*SIZE-1:0] alu_values,
  output logic [1:0]                   alu_load,
  output logic                         alu_enable,
  output logic                         alu_clear,
  input  logic [SIZE-1:0]              alu_value,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [SIZE-1:0]              out_data,
  output logic [AW-1:0]                out_index,
  output logic                         out_last,
  output logic                         busy,
  output logic [2:0]                   dbg_state
);

  if (PRECISION >= SIZE || N_OUT < 1) begin : g_param_check
    $error("fc_alu_sequencer: PRECISION must be below SIZE and N_OUT must be at least 1");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_LOADV, S_FETCH, S_LOADW, S_COMPUTE, S_CAPTURE, S_OUTPUT
  } state_t;

  localparam logic [1:0] LD_VALUES = 2'd0;
  localparam logic [1:0] LD_WEIGHT = 2'd1;
  localparam logic [1:0] LD_HOLD   = 2'd2;

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
  // out_valid holds its payload stable until accepted; in_ready is high only in IDLE.

  state_t                         r_state;
  logic [AW-1:0]                  r_n;
  logic                           r_in_ready;
  logic                           r_mem_rd;
  logic [AW-1:0]                  r_mem_addr;
  logic [(INPUT_SZ+1)*SIZE-1:0]   r_alu_vals;
  logic [1:0]                     r_alu_load;
  logic                           r_alu_enable;
  logic                           r_alu_clear;
  logic                           r_out_valid;
  logic [SIZE-1:0]                r_out_data;
  logic [AW-1:0]                  r_out_index;
  logic                           r_out_last;
  logic                           r_busy;

  // Outputs are set on entry to each state, so every control bit is a pure state decode.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_n          <= '0;
      r_in_ready   <= 1'b1;
      r_mem_rd     <= 1'b0;
      r_mem_addr   <= '0;
      r_alu_vals   <= '0;
      r_alu_load   <= LD_HOLD;
      r_alu_enable <= 1'b0;
      r_alu_clear  <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_index  <= '0;
      r_out_last   <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_state     <= S_LOADV;
            r_n         <= '0;
            r_in_ready  <= 1'b0;
            r_busy      <= 1'b1;
            r_alu_load  <= LD_VALUES;
            r_alu_vals  <= {in_values, {SIZE{1'b0}}};
            r_alu_clear <= 1'b1;
          end
        end
        S_LOADV: begin
          r_state     <= S_FETCH;
          r_alu_clear <= 1'b0;
          r_alu_load  <= LD_HOLD;
          r_mem_rd    <= 1'b1;
          r_mem_addr  <= r_n;
        end
        S_FETCH: begin
          r_state    <= S_LOADW;
          r_mem_rd   <= 1'b0;
          r_alu_load <= LD_WEIGHT;
        end
        S_LOADW: begin
          r_state      <= S_COMPUTE;
          r_alu_load   <= LD_HOLD;
          r_alu_enable <= 1'b1;
        end
        S_COMPUTE: begin
          r_state      <= S_CAPTURE;
          r_alu_enable <= 1'b0;
        end
        S_CAPTURE: begin
          r_state     <= S_OUTPUT;
          r_out_data  <= alu_value;
          r_out_index <= r_n;
          r_out_last  <= (r_n == AW'(N_OUT - 1));
          r_out_valid <= 1'b1;
        end
        S_OUTPUT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            if (r_out_last) begin
              r_state    <= S_IDLE;
              r_in_ready <= 1'b1;
              r_busy     <= 1'b0;
            end else begin
              r_state    <= S_FETCH;
              r_n        <= r_n + 1'b1;
              r_mem_rd   <= 1'b1;
              r_mem_addr <= r_n + 1'b1;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Weight words reach the ALU straight from memory; the vector word is held in a register.
  assign alu_values = (r_state == S_LOADW) ? mem_rdata : r_alu_vals;

  assign in_ready   = r_in_ready;
  assign mem_rd     = r_mem_rd;
  assign mem_addr   = r_mem_addr;
  assign alu_load   = r_alu_load;
  assign alu_enable = r_alu_enable;
  assign alu_clear  = r_alu_clear;
  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign out_index  = r_out_index;
  assign out_last   = r_out_last;
  assign busy       = r_busy;
  assign dbg_state  = r_state;

endmodule
